// File: rtl/fetch_sequencer.sv
// Run-control FSM for the instruction-fetch stage: start/done handshake, memory stalls, halt.
// Optional cycle counter enabled by defining FETCH_SEQ_CYCLE_COUNT_EN.
module fetch_sequencer #(
    parameter int D            = 12,
    parameter int STALL_CYCLES = 2,
    parameter int CW           = 16
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          Start,
    input  logic          HaltInstr,
    input  logic          MemAccess,
    input  logic          BranchReq,
    output logic          Init,
    output logic          Halt,
    output logic          BranchEn,
    output logic          Done,
    output logic          Busy
`ifdef FETCH_SEQ_CYCLE_COUNT_EN
    ,
    output logic [CW-1:0] CycleCount
`endif
);

    localparam int SCW = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [SCW-1:0] STALL_LOAD = (STALL_CYCLES > 0) ? SCW'(STALL_CYCLES - 1) : '0;

    // D only has to agree with the fetch stage's PC width; reject nonsense at elaboration.
    if (D < 1 || CW < 1 || STALL_CYCLES < 0) begin : g_bad_params
        $error("fetch_sequencer: invalid parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_STALL,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [SCW-1:0] r_stall_cnt;
    logic [SCW-1:0] w_stall_cnt_nxt;
    logic           r_start_q;
    logic           w_start_rise;
    logic           w_mem_stall;

    assign w_start_rise = Start & ~r_start_q;
    assign w_mem_stall  = MemAccess && (STALL_CYCLES > 0);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
            r_start_q   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_start_q   <= Start;
        end
    end

    // Halt/BranchEn in RUN are Mealy so the PC freezes on the same edge that decodes halt or mem.
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        Init            = 1'b0;
        Halt            = 1'b1;
        BranchEn        = 1'b0;
        Done            = 1'b0;
        Busy            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                Init        = 1'b1;
                Busy        = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                Busy = 1'b1;
                if (HaltInstr) begin
                    w_state_nxt = S_DONE;
                end else if (w_mem_stall) begin
                    w_stall_cnt_nxt = STALL_LOAD;
                    w_state_nxt     = S_STALL;
                end else begin
                    Halt     = 1'b0;
                    BranchEn = BranchReq;
                end
            end
            S_STALL: begin
                Busy = 1'b1;
                if (r_stall_cnt != '0) begin
                    w_stall_cnt_nxt = r_stall_cnt - 1'b1;
                end else begin
                    Halt        = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                Done = 1'b1;
                if (w_start_rise) begin
                    w_state_nxt = S_INIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef FETCH_SEQ_CYCLE_COUNT_EN
    logic [CW-1:0] r_cycle_cnt;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_cycle_cnt <= '0;
        end else if ((r_state == S_RUN || r_state == S_STALL) && r_cycle_cnt != '1) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign CycleCount = r_cycle_cnt;
`endif

endmodule
